// File: rtl/vga_timing.sv
// VGA raster timing generator: column/line counters with registered sync,
// visible-area, frame-start and frame-count outputs, all advanced by pix_en.
module vga_timing #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   output logic [9:0] colPos,
   output logic [9:0] rowPos,
   output logic       hsync,
   output logic       vsync,
   output logic       visible,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic       col_wrap;
   logic       row_wrap;
   logic       frame_wrap;
   logic [9:0] col_nxt;
   logic [9:0] row_nxt;

   // Next counter position; the decoded outputs are derived from it so they
   // land in the same register stage as the counters (zero skew).
   always_comb begin
      col_wrap   = (colPos == H_LAST);
      row_wrap   = (rowPos == V_LAST);
      frame_wrap = col_wrap && row_wrap;
      col_nxt    = col_wrap ? '0 : colPos + 10'd1;
      row_nxt    = rowPos;
      if (col_wrap)
         row_nxt = row_wrap ? '0 : rowPos + 10'd1;
   end

   // Counters and registered timing outputs; frame_start is a single-clock pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         colPos      <= '0;
         rowPos      <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         visible     <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_start <= pix_en && frame_wrap;
         if (pix_en) begin
            colPos  <= col_nxt;
            rowPos  <= row_nxt;
            hsync   <= !((col_nxt >= HS_BEG) && (col_nxt <= HS_END));
            vsync   <= !((row_nxt >= VS_BEG) && (row_nxt <= VS_END));
            visible <= (col_nxt < H_VIS) && (row_nxt < V_VIS);
            if (frame_wrap)
               frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels; H_TOTAL = sum = 800.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines; V_TOTAL = sum = 525.
REQ-009 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock, rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have pix_en  input  1  pixel-advance enable, sampled on clk rising edge.
REQ-011 SHALL have colPos  output  10  current column, 0..H_TOTAL-1, feeds pattern generator.
REQ-012 SHALL have rowPos  output  10  current line, 0..V_TOTAL-1, feeds pattern generator.
REQ-013 SHALL have hsync  output  1  horizontal sync, active low.
REQ-014 SHALL have vsync  output  1  vertical sync, active low.
REQ-015 SHALL have visible  output  1  high when current position lies in the visible area.
REQ-016 SHALL have frame_start  output  1  one-clk pulse at start of each frame.
REQ-017 SHALL have frame_count  output  8  completed-frame counter for animation.

Function
REQ-018 SHALL hold all state unchanged on any clk edge with pix_en=0, except frame_start (REQ-024).
REQ-019 SHALL, on an edge with pix_en=1, increment colPos; at colPos=H_TOTAL-1 wrap colPos to 0 and advance rowPos.
REQ-020 SHALL wrap rowPos from V_TOTAL-1 to 0 on the same edge colPos wraps; otherwise increment rowPos by 1 on colPos wrap.
REQ-021 SHALL register hsync, vsync and visible on the same edge as the counters, computed from the next counter values, so all outputs are glitch-free and mutually aligned (zero-cycle skew vs colPos/rowPos).
REQ-022 SHALL drive hsync=0 iff H_VISIBLE+H_FRONT <= colPos <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751 default).
REQ-023 SHALL drive vsync=0 iff V_VISIBLE+V_FRONT <= rowPos <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491 default), for the whole of each such line.
REQ-024 SHALL set frame_start=1 on the edge where the counters wrap (H_TOTAL-1,V_TOTAL-1)->(0,0), and clear it on the next clk edge regardless of pix_en.
REQ-025 SHALL drive visible=1 iff colPos < H_VISIBLE and rowPos < V_VISIBLE.
REQ-026 SHALL increment frame_count by 1 on each frame wrap, modulo 256 (255 -> 0).
REQ-027 SHALL use unsigned arithmetic; counters never exceed H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-028 SHALL, while rst_n=0, immediately force colPos=0, rowPos=0, hsync=1, vsync=1, visible=0, frame_start=0, frame_count=0, independent of clk.
REQ-029 SHALL, on the first pix_en=1 edge after rst_n deasserts, produce colPos=1, rowPos=0, visible=1, frame_start=0.
REQ-030 SHALL treat reset asserted mid-frame identically to power-up reset; no partial-frame state survives.

Verification
REQ-031 Reset, pix_en=1 constant: after 655 edges colPos=655, hsync=1; after 656 hsync=0; after 752 hsync=1.
REQ-032 colPos=799, rowPos=10, pix_en=1 edge -> colPos=0, rowPos=11, visible=1.
REQ-033 Free run: vsync=0 exactly while rowPos in {490,491} (1600 enabled edges), 1 otherwise.
REQ-034 Reset, 420000 enabled edges -> colPos=0, rowPos=0, frame_start=1 for one clk, frame_count=1; after 256 frames frame_count=0.
REQ-035 pix_en toggling 1,0,1,0: line period 1600 clk, frame_start still exactly one clk wide, counters hold on pix_en=0 edges.
REQ-036 At colPos=300, rowPos=100 assert rst_n=0 between edges -> all outputs reach reset values before the next clk edge.
